// File: rtl/uart_rx_capture.sv
// uart_rx_capture: 8N1 UART receiver feeding a small byte FIFO.
//
// The rx pin is asynchronous. It is brought into the clock domain through a
// two-flop synchronizer, and every decision is made on the synchronized copy.
// Each received byte is written into a FIFO. The consumer drains the FIFO
// through a valid/ready handshake.
//
// Optional build macro: UART_RX_PARITY_EN
//   When defined, the receiver expects an even-parity bit between the data
//   bits and the stop bit, and the parity_err port is added.
//
// Ports:
//   clock        system clock, rising edge
//   resetb       asynchronous active-low reset
//   rx           serial input, idles high
//   rx_data      byte at the FIFO head, 8'h00 when the FIFO is empty
//   rx_valid     FIFO not empty
//   rx_ready     consumer accepts rx_data when rx_valid & rx_ready
//   fifo_count   number of entries held in the FIFO
//   line_done    one-cycle pulse when 8'h0A is written into the FIFO
//   framing_err  sticky, set when a stop bit is sampled low
//   overflow     sticky, set when a byte is dropped because the FIFO is full
//   clr_err      synchronous clear of the sticky error flags
//   parity_err   (UART_RX_PARITY_EN only) sticky parity mismatch flag
//
// Receiver states:
//   state     | meaning
//   IDLE      | line idle; waiting for a falling edge on rx_s
//   START     | waiting half a bit, then confirming the start bit is still low
//   DATA      | sampling 8 data bits, LSB first, once per bit period
//   PARITY    | sampling the even-parity bit (UART_RX_PARITY_EN only)
//   STOP      | sampling the stop bit; push the byte or flag a framing error
//   WAIT_HIGH | after a framing error, wait for the line to return high
module uart_rx_capture #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          line_done,
  output logic                          framing_err,
  output logic                          overflow,
  input  logic                          clr_err
`ifdef UART_RX_PARITY_EN
  , output logic                        parity_err
`endif
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic          r_rx_meta, r_rx_s, r_rx_prev;
  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [2:0]    r_bit_idx, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_tick, w_push, w_frame_set;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_line_done, r_framing_err, r_overflow;
  logic          w_pop, w_full, w_wr, w_drop;

`ifdef UART_RX_PARITY_EN
  logic          r_par_bad, w_par_bad_nxt, w_par_set, r_parity_err;
`endif

  // Presetting the synchronizer to 1 keeps reset release from looking like a start bit.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_tick = (r_timer == '0);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= w_par_bad_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
    w_par_set     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_rx_prev && !r_rx_s) begin
          w_timer_nxt = T_HALF;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (!w_tick) begin
          w_timer_nxt = r_timer - TW'(1);
        end else if (!r_rx_s) begin
          w_timer_nxt = T_FULL;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
`ifdef UART_RX_PARITY_EN
          w_par_bad_nxt = 1'b0;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (!w_tick) begin
          w_timer_nxt = r_timer - TW'(1);
        end else begin
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          w_timer_nxt = T_FULL;
          w_bit_nxt   = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (!w_tick) begin
          w_timer_nxt = r_timer - TW'(1);
        end else begin
          // Even parity: data bits plus the parity bit hold an even number of ones.
          w_par_bad_nxt = (r_rx_s != (^r_shift));
          w_par_set     = w_par_bad_nxt;
          w_timer_nxt   = T_FULL;
          w_state_nxt   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!w_tick) begin
          w_timer_nxt = r_timer - TW'(1);
        end else if (r_rx_s) begin
`ifdef UART_RX_PARITY_EN
          w_push = !r_par_bad;
`else
          w_push = 1'b1;
`endif
          w_state_nxt = S_IDLE;
        end else begin
          w_frame_set = 1'b1;
          w_state_nxt = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds.
  assign rx_valid = (r_count != '0);
  assign w_pop    = rx_valid & rx_ready;
  assign w_full   = (r_count == DEPTH);
  assign w_wr     = w_push & (!w_full | w_pop);
  assign w_drop   = w_push & w_full & !w_pop;

  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wptr] <= r_shift;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_line_done   <= 1'b0;
      r_framing_err <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + (AW + 1)'(1);
      else if (!w_wr && w_pop) r_count <= r_count - (AW + 1)'(1);
      r_line_done   <= w_wr && (r_shift == 8'h0A);
      // A new error in the same cycle as clr_err keeps its flag set.
      r_framing_err <= w_frame_set | (r_framing_err & !clr_err);
      r_overflow    <= w_drop | (r_overflow & !clr_err);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) r_parity_err <= 1'b0;
    else         r_parity_err <= w_par_set | (r_parity_err & !clr_err);
  end
  assign parity_err = r_parity_err;
`endif

  assign rx_data     = rx_valid ? r_mem[r_rptr] : 8'h00;
  assign fifo_count  = r_count;
  assign line_done   = r_line_done;
  assign framing_err = r_framing_err;
  assign overflow    = r_overflow;

endmodule
